// File: rtl/sw_timebase_ctrl.sv
// Purpose : stopwatch front end; debounces the start/stop and clear buttons, runs the IDLE/RUN/PAUSE
//           control FSM and generates the counter enable, clear strobe and tick for the counter chain.
// Latency : button step -> FSM reaction DB_CYCLES+2 clocks; first tick falling edge DIV clocks after cnt_en.
// Backpressure: none; outputs are free-running levels/strobes and the downstream chain always accepts them.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   btn_ss, btn_clr    raw asynchronous push-buttons (high = pressed)
//   pls_out            half-duty tick, falling edge once per DIV clocks while running
//   cnt_en / running   high while in RUN
//   clr                one-cycle clear strobe
// Optional build macro LAP_EN adds btn_lap (input) and lap_frz (output, display freeze toggle).
module sw_timebase_ctrl #(
  parameter int CLK_HZ    = 125000000,
  parameter int TICK_HZ   = 100,
  parameter int DB_CYCLES = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_ss,
  input  logic btn_clr,
`ifdef LAP_EN
  input  logic btn_lap,
`endif
  output logic pls_out,
  output logic cnt_en,
  output logic clr,
  output logic running
`ifdef LAP_EN
  ,
  output logic lap_frz
`endif
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Button vector: bit 0 = start/stop, bit 1 = clear, bit 2 = lap (optional)
`ifdef LAP_EN
  localparam int NB = 3;
  logic [NB-1:0] btn_raw;
  assign btn_raw = {btn_lap, btn_clr, btn_ss};
`else
  localparam int NB = 2;
  logic [NB-1:0] btn_raw;
  assign btn_raw = {btn_clr, btn_ss};
`endif

  logic [NB-1:0]  sync1, sync2;
  logic [NB-1:0]  db_lvl, db_lvl_d;
  logic [DBW-1:0] db_cnt [NB];
  logic [NB-1:0]  press;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      db_lvl   <= '0;
      db_lvl_d <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      db_lvl_d <= db_lvl;
      for (int i = 0; i < NB; i++) begin
        // Any cycle of agreement restarts the stability window.
        if (sync2[i] != db_lvl[i]) begin
          if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
            db_lvl[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Press only (0->1); release is silent.
  assign press = db_lvl & ~db_lvl_d;

  logic ev_ss, ev_clr;
  assign ev_ss  = press[0];
  assign ev_clr = press[1];

  logic [1:0] state, state_nxt;
  logic       clr_nxt;

  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev_clr)     clr_nxt   = 1'b1;
        else if (ev_ss) state_nxt = ST_RUN;
      end
      // Clear is ignored while running: the chain only honours clr with cnt_en low.
      ST_RUN: begin
        if (ev_ss) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (ev_clr) begin
          state_nxt = ST_IDLE;
          clr_nxt   = 1'b1;
        end else if (ev_ss) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic [DW-1:0] div_cnt, div_inc;
  assign div_inc = (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + DW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      clr     <= 1'b0;
      cnt_en  <= 1'b0;
      div_cnt <= '0;
      pls_out <= 1'b0;
    end else begin
      state  <= state_nxt;
      clr    <= clr_nxt;
      cnt_en <= (state_nxt == ST_RUN);
      // The divider advances on every edge that starts in RUN, including the
      // edge that leaves RUN; PAUSE then holds the partial period.
      if (clr_nxt) begin
        div_cnt <= '0;
        pls_out <= 1'b0;
      end else if (state == ST_RUN) begin
        div_cnt <= div_inc;
        pls_out <= (div_inc >= DW'(DIV / 2));
      end
    end
  end

  assign running = cnt_en;

`ifdef LAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_frz <= 1'b0;
    end else if (clr_nxt) begin
      lap_frz <= 1'b0;
    end else if (state == ST_RUN && press[2]) begin
      lap_frz <= ~lap_frz;
    end
  end
`endif

endmodule

// File: tb/tb_sw_timebase_ctrl.sv
module tb_sw_timebase_ctrl;

  logic clk = 1'b0;
  logic rst, btn_ss, btn_clr;
  logic pls_out, cnt_en, clr, running;
`ifdef LAP_EN
  logic btn_lap, lap_frz;
`endif

  int n_vec = 0;
  int n_err = 0;
  int clr_seen = 0;

  always #5 clk = ~clk;

  sw_timebase_ctrl #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .DB_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
`ifdef LAP_EN
    .btn_lap (btn_lap),
    .lap_frz (lap_frz),
`endif
    .pls_out (pls_out),
    .cnt_en  (cnt_en),
    .clr     (clr),
    .running (running)
  );

  // Cycles with clr high, sampled mid-cycle.
  always @(negedge clk) if (clr === 1'b1) clr_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_ss = v;
      1: btn_clr = v;
`ifdef LAP_EN
      2: btn_lap = v;
`endif
      default: ;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    set_btn(which, 1'b1);
    tick(hold);
    set_btn(which, 1'b0);
    tick(8);
  endtask

  task automatic wait_div(input int val);
    for (int i = 0; i < 20; i++) begin
      if (dut.div_cnt == val) break;
      tick(1);
    end
  endtask

  initial begin
    int bad, n, falls, first_fall, nchg, fall_at, c0;
    logic prev, found;

    rst = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0;
`ifdef LAP_EN
    btn_lap = 1'b0;
`endif
    tick(3);
    chk("rst_pls", pls_out, 0);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_clr", clr, 0);
    chk("rst_running", running, 0);
    chk("rst_state", dut.state, 0);
    chk("rst_div", dut.div_cnt, 0);
    rst = 1'b0;

    // 1: idle with no buttons
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (pls_out !== 1'b0 || cnt_en !== 1'b0 || clr !== 1'b0 || dut.state !== 2'd0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // 2: start, latency and tick waveform
    btn_ss = 1'b1;
    fork begin tick(10); btn_ss = 1'b0; end join_none
    n = -1; found = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      tick(1);
      if (cnt_en === 1'b1) begin found = 1'b1; n = i - 1; end
    end
    chk("ss_latency", n, 6);
    chk("running_on", running, 1);
    bad = 0; falls = 0; first_fall = -1; prev = pls_out;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (pls_out !== ((k % 10) >= 5)) bad++;
      if (prev === 1'b1 && pls_out === 1'b0) begin
        falls++;
        if (first_fall < 0) first_fall = k;
      end
      prev = pls_out;
    end
    chk("tick_pattern", bad, 0);
    chk("tick_falls", falls, 3);
    chk("first_fall", first_fall, 10);

    // 3: bounce then settle high -> one event (RUN -> PAUSE)
    nchg = 0; fall_at = -1; prev = cnt_en;
    for (int i = 0; i < 60; i++) begin
      btn_ss = (i >= 20) ? 1'b1 : (((i / 2) % 2) == 0);
      tick(1);
      if (cnt_en !== prev) begin
        nchg++;
        if (fall_at < 0) fall_at = i;
      end
      prev = cnt_en;
    end
    chk("bounce_events", nchg, 1);
    chk("bounce_fall_at", fall_at, 26);
    chk("bounce_paused", cnt_en, 0);
    btn_ss = 1'b0;
    tick(10);

    // 4: pause at div_cnt=7, hold, resume finishes the period
    press(0, 8);
    wait_div(0);
    btn_ss = 1'b1;
    tick(7);
    chk("pause_cnt_en", cnt_en, 0);
    chk("pause_div", dut.div_cnt, 7);
    chk("pause_pls", pls_out, 1);
    tick(10);
    chk("pause_hold_div", dut.div_cnt, 7);
    chk("pause_hold_pls", pls_out, 1);
    btn_ss = 1'b0;
    tick(10);
    btn_ss = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (cnt_en === 1'b1) found = 1'b1;
    end
    n = -1;
    for (int k = 1; k <= 20 && found; k++) begin
      tick(1);
      if (pls_out === 1'b0) begin n = k; break; end
    end
    chk("resume_fall", n, 3);
    btn_ss = 1'b0;
    tick(10);

    // 5: clear handling
    c0 = clr_seen;
    press(1, 8);
    chk("run_clr_ignored", clr_seen - c0, 0);
    chk("run_clr_cnt_en", cnt_en, 1);
    press(0, 8);
    chk("stop_cnt_en", cnt_en, 0);
    c0 = clr_seen;
    press(1, 8);
    chk("pause_clr_strobe", clr_seen - c0, 1);
    chk("pause_clr_state", dut.state, 0);
    chk("pause_clr_div", dut.div_cnt, 0);
    chk("pause_clr_pls", pls_out, 0);
    c0 = clr_seen;
    press(1, 8);
    chk("idle_clr_strobe", clr_seen - c0, 1);
    chk("idle_clr_state", dut.state, 0);
    press(0, 8);
    press(0, 8);
    c0 = clr_seen;
    btn_ss = 1'b1; btn_clr = 1'b1;
    tick(8);
    btn_ss = 1'b0; btn_clr = 1'b0;
    tick(8);
    chk("both_clr_strobe", clr_seen - c0, 1);
    chk("both_state", dut.state, 0);
    tick(20);
    chk("both_stays_idle", cnt_en, 0);

    // 6: reset mid-run
    press(0, 8);
    wait_div(6);
    chk("pre_rst_pls", pls_out, 1);
    rst = 1'b1;
    tick(1);
    chk("midrst_pls", pls_out, 0);
    chk("midrst_cnt_en", cnt_en, 0);
    chk("midrst_running", running, 0);
    chk("midrst_state", dut.state, 0);
    chk("midrst_div", dut.div_cnt, 0);
    rst = 1'b0;
    tick(5);

`ifdef LAP_EN
    press(0, 8);
    press(2, 8);
    chk("lap_set", lap_frz, 1);
    press(0, 8);
    chk("lap_hold_pause", lap_frz, 1);
    press(1, 8);
    chk("lap_clr", lap_frz, 0);
    chk("lap_clr_state", dut.state, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
